// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared encodings and types for the hazard scoreboard
package hazard_scoreboard_pkg;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_E = 2'd0;
  localparam logic [1:0] TNEW_M = 2'd1;
  localparam logic [1:0] TNEW_W = 2'd2;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_M   = 2'd1;
  localparam logic [1:0] FWD_E   = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic [1:0] tnew;
  } hz_entry_t;

  function automatic logic [1:0] sat_dec(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  // The MD counter must hold the longest busy period and is never narrower than 4 bits.
  function automatic int md_cnt_width(input int max_cycles);
    int w;
    w = $clog2(max_cycles + 1);
    return (w > 4) ? w : 4;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - D-stage operand/MD inputs and stall/forward outputs
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [4:0] d_dst;
  logic       d_wen;
  logic [1:0] d_tnew;
  logic       d_is_md;
  logic       e_md_start;
  logic       e_md_div;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic       md_busy;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_wen, d_tnew, d_is_md,
    output e_md_start, e_md_div,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_wen, d_tnew, d_is_md,
    input  e_md_start, e_md_div,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

endinterface

// File: rtl/hazard_scoreboard_hz_src_check.sv
// rtl/hazard_scoreboard_hz_src_check.sv - stall and forward select for one D-stage source
module hz_src_check
  import hazard_scoreboard_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [1:0] tuse_i,
  input  hz_entry_t  e_i,
  input  hz_entry_t  m_i,
  output logic       stall_o,
  output logic [1:0] fwd_sel_o
);

  logic match_e;
  logic match_m;

  always_comb begin
    match_e = e_i.valid && (e_i.addr == src_i) && (src_i != 5'd0);
    match_m = m_i.valid && (m_i.addr == src_i) && (src_i != 5'd0);

    stall_o = (tuse_i != TUSE_NONE) &&
              ((match_e && (e_i.tnew > tuse_i)) || (match_m && (m_i.tnew > tuse_i)));

    // A pending E match hides M even when M is ready: E holds the newer value.
    fwd_sel_o = FWD_GRF;
    if (match_e) begin
      if (e_i.tnew == TNEW_E) fwd_sel_o = FWD_E;
    end else if (match_m && (m_i.tnew == TNEW_E)) begin
      fwd_sel_o = FWD_M;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M write shadow, stall/forward generation and MD busy counter
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic              clk,
  input logic              reset,
  hazard_scoreboard_if.slave hz
);

  localparam int MD_CNT_W = md_cnt_width(DIV_CYCLES);

  hz_entry_t             e_q, e_d;
  hz_entry_t             m_q, m_d;
  logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;

  logic       rs_stall, rt_stall, md_stall;
  logic       stall_w, md_busy_w;
  logic [1:0] rs_sel, rt_sel;

  hz_src_check u_rs (
    .src_i     (hz.d_rs),
    .tuse_i    (hz.d_tuse_rs),
    .e_i       (e_q),
    .m_i       (m_q),
    .stall_o   (rs_stall),
    .fwd_sel_o (rs_sel)
  );

  hz_src_check u_rt (
    .src_i     (hz.d_rt),
    .tuse_i    (hz.d_tuse_rt),
    .e_i       (e_q),
    .m_i       (m_q),
    .stall_o   (rt_stall),
    .fwd_sel_o (rt_sel)
  );

  always_comb begin
    md_busy_w = hz.e_md_start || (md_cnt_q != '0);
    md_stall  = hz.d_is_md && md_busy_w;
    stall_w   = rs_stall || rt_stall || md_stall;

    m_d.valid = e_q.valid;
    m_d.addr  = e_q.addr;
    m_d.tnew  = sat_dec(e_q.tnew);

    // A stalled D instruction is re-issued later, so only a bubble enters E now.
    e_d = '0;
    if (!stall_w) begin
      e_d.valid = hz.d_wen && (hz.d_dst != 5'd0);
      e_d.addr  = hz.d_dst;
      e_d.tnew  = hz.d_tnew;
    end

    md_cnt_d = md_cnt_q;
    if (hz.e_md_start) begin
      md_cnt_d = hz.e_md_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q      <= '0;
      m_q      <= '0;
      md_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign hz.stall      = stall_w;
  assign hz.fwd_rs_sel = rs_sel;
  assign hz.fwd_rt_sel = rt_sel;
  assign hz.md_busy    = md_busy_w;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard-driven bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tur;
    logic [1:0] tut;
    logic [4:0] dst;
    logic       wen;
    logic [1:0] tnew;
    logic       md;
    logic       st;
    logic       dv;
    logic [5:0] exp;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;
  logic [5:0] exp_q[$];

  hazard_scoreboard_if hz ();

  hazard_scoreboard #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  function automatic step_t mk(int rs, int rt, int tur, int tut, int dst, int wen, int tnew,
                               int md, int st, int dv, int x_st, int x_rs, int x_rt, int x_bz);
    step_t s;
    s.rs = 5'(rs); s.rt = 5'(rt); s.tur = 2'(tur); s.tut = 2'(tut);
    s.dst = 5'(dst); s.wen = 1'(wen); s.tnew = 2'(tnew);
    s.md = 1'(md); s.st = 1'(st); s.dv = 1'(dv);
    s.exp = {1'(x_st), 2'(x_rs), 2'(x_rt), 1'(x_bz)};
    return s;
  endfunction

  function automatic step_t idle();
    return mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input step_t s);
    hz.d_rs = s.rs; hz.d_rt = s.rt; hz.d_tuse_rs = s.tur; hz.d_tuse_rt = s.tut;
    hz.d_dst = s.dst; hz.d_wen = s.wen; hz.d_tnew = s.tnew;
    hz.d_is_md = s.md; hz.e_md_start = s.st; hz.e_md_div = s.dv;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got, want;
    reset = 1'b1;
    apply(idle());
    repeat (2) @(posedge clk);
    exp_q.push_back(6'b0);
    @(negedge clk);
    got = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy};
    want = exp_q.pop_front();
    n_total++;
    if (got !== want) $display("FAIL reset: got stall/rs/rt/busy=%b required %b", got, want);
    else n_pass++;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_load_use();
    step_t s[7];
    logic [5:0] got, want;
    s[0] = mk(0, 0, 3, 3, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    s[1] = mk(1, 2, 1, 0, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    s[2] = mk(1, 2, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    s[3] = mk(2, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    s[4] = mk(2, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    s[5] = idle();
    s[6] = idle();
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL load_use step %0d: got stall/rs/rt/busy=%b required %b", i, got, want);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_branch();
    step_t s[5];
    logic [5:0] got, want;
    s[0] = mk(0, 0, 3, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    s[1] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    s[2] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    s[3] = idle();
    s[4] = idle();
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL branch step %0d: got stall/rs/rt/busy=%b required %b", i, got, want);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_newest_wins();
    step_t s[9];
    logic [5:0] got, want;
    s[0] = mk(0, 0, 3, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    s[1] = mk(0, 0, 3, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    s[2] = mk(0, 5, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    s[3] = mk(0, 0, 3, 3, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    s[4] = mk(0, 0, 3, 3, 6, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    s[5] = mk(6, 6, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s[6] = mk(6, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    s[7] = idle();
    s[8] = idle();
    for (int i = 0; i < 9; i++) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL newest_wins step %0d: got stall/rs/rt/busy=%b required %b", i, got, want);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_reg_zero();
    step_t s[3];
    logic [5:0] got, want;
    s[0] = mk(0, 0, 3, 3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    s[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s[2] = idle();
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL reg_zero step %0d: got stall/rs/rt/busy=%b required %b", i, got, want);
      else n_pass++;
      next_cycle();
    end
  endtask

  // Each window: a start at k=0, then mflo in D for `len` cycles; busy/stall expected for k<=n.
  task automatic test_md_busy();
    logic [5:0] got, want;
    int n, len, bz;
    for (int w = 0; w < 3; w++) begin
      n   = (w == 1) ? MULT_N : DIV_N;
      len = n + 1;
      apply(mk(0, 0, 3, 3, 0, 0, 0, 0, 1, (w == 1) ? 0 : 1, 0, 0, 0, 1));
      exp_q.push_back(6'b000001);
      @(negedge clk);
      got = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL md_start window %0d: got stall/rs/rt/busy=%b required %b", w, got, want);
      else n_pass++;
      next_cycle();
      if (w == 2) begin
        for (int k = 1; k <= 3; k++) begin
          apply(mk(0, 0, 3, 3, 0, 0, 0, 0, (k == 3) ? 1 : 0, 0, 0, 0, 0, 1));
          exp_q.push_back(6'b000001);
          @(negedge clk);
          got = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy};
          want = exp_q.pop_front();
          n_total++;
          if (got !== want) $display("FAIL md_reload k=%0d: got stall/rs/rt/busy=%b required %b", k, got, want);
          else n_pass++;
          next_cycle();
        end
        n   = MULT_N;
        len = n + 1;
      end
      for (int k = 1; k <= len; k++) begin
        bz = (k <= n) ? 1 : 0;
        apply(mk(0, 0, 3, 3, 0, 0, 0, 1, 0, 0, bz, 0, 0, bz));
        exp_q.push_back({1'(bz), 4'b0, 1'(bz)});
        @(negedge clk);
        got = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy};
        want = exp_q.pop_front();
        n_total++;
        if (got !== want) $display("FAIL md_window %0d k=%0d: got stall/rs/rt/busy=%b required %b", w, k, got, want);
        else n_pass++;
        next_cycle();
      end
    end
    apply(idle());
  endtask

  task automatic test_reset_mid();
    step_t s[6];
    logic [5:0] got, want;
    s[0] = mk(0, 0, 3, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    s[1] = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    s[2] = mk(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    s[3] = mk(0, 0, 3, 3, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    s[4] = mk(1, 0, 0, 3, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    s[5] = mk(1, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      if (i == 4) reset = 1'b1;
      exp_q.push_back(s[i].exp);
      @(negedge clk);
      got = {hz.stall, hz.fwd_rs_sel, hz.fwd_rt_sel, hz.md_busy};
      want = exp_q.pop_front();
      n_total++;
      if (got !== want) $display("FAIL reset_mid step %0d: got stall/rs/rt/busy=%b required %b", i, got, want);
      else n_pass++;
      next_cycle();
      reset = 1'b0;
    end
    apply(idle());
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_newest_wins();
    test_reg_zero();
    test_md_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
